// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, default latencies and the HI/LO result type shared by the multiply/divide unit.
package mdu_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MTHI  = 3'b001;
  localparam logic [2:0] OP_MTLO  = 3'b010;
  localparam logic [2:0] OP_RSVD  = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_MULTU = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply/divide producing the {hi,lo} pair and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    r,
  output logic        dz
);
  logic [31:0] db, uq, ur;
  logic signed [31:0] sq, sr;
  logic signed [63:0] sp;
  logic [63:0] up;
  assign dz = op[2] & op[1] & (b == 32'd0);
  // dividing by 1 yields the required results for both div-by-zero (discarded) and 0x80000000 / -1
  assign db = (b == 32'd0 || (op == OP_DIV && a == 32'h8000_0000 && b == 32'hffff_ffff)) ? 32'd1 : b;
  assign sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign up = {32'd0, a} * {32'd0, b};
  assign sq = $signed(a) / $signed(db);
  assign sr = $signed(a) % $signed(db);
  assign uq = a / db;
  assign ur = a % db;
  always_comb
    r = op == OP_MULT  ? sp :
        op == OP_MULTU ? up :
        op == OP_DIV   ? {sr, sq} : {ur, uq};
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: MIPS HI/LO multiply/divide unit with fixed multi-cycle latency signalled by busy.
// Define MDU_ZERO_LATENCY_EN to write results at the accepting edge with busy tied low.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);
  mdu_res_t r;
  logic dz;
  mdu_arith u_arith (.op(MDU_op), .a(A), .b(B), .r(r), .dz(dz));
`ifdef MDU_ZERO_LATENCY_EN
  assign busy = 1'b0;
  always_ff @(posedge clk or posedge res)
    if (res) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (start) begin
      if (MDU_op[2] && !dz) begin
        HI <= r.hi;
        LO <= r.lo;
      end else if (MDU_op == OP_MTHI) HI <= A;
      else if (MDU_op == OP_MTLO) LO <= A;
    end
`else
  localparam int CW = $clog2((DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES) + 1);
  logic [CW-1:0] cnt;
  mdu_res_t pend;
  logic pend_wr;
  always_ff @(posedge clk or posedge res)
    if (res) begin
      HI      <= 32'd0;
      LO      <= 32'd0;
      busy    <= 1'b0;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (pend_wr) begin
          HI <= pend.hi;
          LO <= pend.lo;
        end
      end
    end else if (start) begin
      if (MDU_op[2]) begin
        busy    <= 1'b1;
        cnt     <= MDU_op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        pend    <= r;
        pend_wr <= !dz;
      end else if (MDU_op == OP_MTHI) HI <= A;
      else if (MDU_op == OP_MTLO) LO <= A;
    end
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench; expected HI/LO and busy length are queued per op and checked when busy falls.
module tb_mul_div_unit;
  logic clk = 0, res = 1, start = 0, busy;
  logic [2:0] MDU_op = 0;
  logic [31:0] A = 0, B = 0, HI, LO;
  int cmp = 0, errs = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int len;
  } exp_t;
  exp_t q[$];

  mul_div_unit dut (.clk(clk), .res(res), .start(start), .MDU_op(MDU_op), .A(A), .B(B),
                    .HI(HI), .LO(LO), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1; MDU_op = op; A = a; B = b;
    @(negedge clk);
    start = 0; MDU_op = 0;
  endtask

  task automatic expect_res(input logic [31:0] hi, input logic [31:0] lo, input int len);
    q.push_back('{hi, lo, len});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    if (busy) begin
      cmp++; errs++;
      $display("FAIL idle_timeout: busy still %b after 50 cycles, required 0", busy);
    end
  endtask

  initial begin : monitor
    int bcnt = 0;
    logic pb = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (res) begin
        bcnt = 0; pb = 0;
      end else begin
        if (busy) bcnt++;
        else if (pb) begin
          if (q.size() == 0) begin
            cmp++; errs++;
            $display("FAIL unexpected_done: busy fell with HI=%h LO=%h, no result expected", HI, LO);
          end else begin
            e = q.pop_front();
            chk("busy_len", 32'(bcnt), 32'(e.len));
            chk("hi", HI, e.hi);
            chk("lo", LO, e.lo);
          end
          bcnt = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", HI, 0); chk("rst_lo", LO, 0); chk("rst_busy", {31'd0, busy}, 0);
    #2 res = 0;
    @(negedge clk);
    expect_res(32'h0000_007d, 32'hffff_fc10, 5);
    issue(3'b101, 32'd126, 32'hffff_fff8);
    chk("hold_hi", HI, 0); chk("hold_lo", LO, 0);
    wait_idle();
    expect_res(32'hffff_ffff, 32'hffff_fc10, 5);
    issue(3'b100, 32'd126, -32'sd8);
    wait_idle();
    expect_res(32'hffff_ffff, 32'hffff_fffd, 10);
    issue(3'b110, -32'sd7, 32'd2);
    wait_idle();
    expect_res(32'hffff_ffff, 32'hffff_fffd, 10);
    issue(3'b111, 32'd7, 32'd0);
    wait_idle();
    issue(3'b001, 32'h1234_5678, 0);
    chk("mthi_hi", HI, 32'h1234_5678); chk("mthi_lo", LO, 32'hffff_fffd);
    chk("mthi_busy", {31'd0, busy}, 0);
    issue(3'b010, 32'h9abc_def0, 0);
    chk("mtlo_lo", LO, 32'h9abc_def0); chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 0);
    expect_res(32'd0, 32'd12, 5);
    issue(3'b101, 32'd3, 32'd4);
    issue(3'b001, 32'h0000_dead, 0);
    chk("busy_mthi_ign", HI, 32'h1234_5678);
    issue(3'b110, 32'd100, 32'd7);
    wait_idle();
    expect_res(32'd0, 32'h8000_0000, 10);
    issue(3'b110, 32'h8000_0000, 32'hffff_ffff);
    wait_idle();
    chk("b2b_done_hi", HI, 0);
    issue(3'b111, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 res = 1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0); chk("midrst_hi", HI, 0); chk("midrst_lo", LO, 0);
    @(negedge clk);
    #2 res = 0;
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
